// File: rtl/jio_ctrl.sv
// IO controller for jcscpu: decodes CU IO strobes and serves a TTY output FIFO,
// a one-deep keyboard register, plain output latches, switch reads and a status byte.
module jio_ctrl #(
  parameter int WIDTH = 8,
  parameter int NDEV  = 4,
  parameter int DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    io_s,
  input  logic                    io_e,
  input  logic                    io_da,
  input  logic                    io_io,
  input  logic [WIDTH-1:0]        bus_in,
  output logic [WIDTH-1:0]        bus_out,
  output logic [WIDTH-1:0]        dev_sel,
  output logic [NDEV*WIDTH-1:0]   dev_out,
  input  logic [WIDTH-1:0]        sw_in,
  output logic [WIDTH-1:0]        tty_data,
  output logic                    tty_valid,
  input  logic                    tty_ready,
  input  logic [WIDTH-1:0]        kbd_data,
  input  logic                    kbd_valid,
  output logic                    kbd_ready,
  output logic                    ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                        io_s_q, io_e_q;
  logic                        rd_da_q, rd_io_q, rd_dev0_q;
  logic [WIDTH-1:0]            sel_q, sel_d;
  logic [NDEV-1:0][WIDTH-1:0]  dev_q, dev_d;
  logic [WIDTH-1:0]            kbd_hold_q, kbd_hold_d;
  logic                        kbd_full_q, kbd_full_d;
  logic                        ovf_q, ovf_d;
  logic [WIDTH-1:0]            mem [DEPTH];
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  logic set_evt, rd_end, data_wr, addr_wr;
  logic sel_zero, sel_in_range, fifo_full, fifo_empty;
  logic pop, push_req, push, drop, rd_data_end, rd_stat_end;

  assign set_evt      = io_s & ~io_s_q;
  assign rd_end       = ~io_e & io_e_q;
  assign addr_wr      = set_evt & io_io & io_da;
  assign data_wr      = set_evt & io_io & ~io_da;
  assign sel_zero     = (sel_q == '0);
  assign sel_in_range = (sel_q < WIDTH'(NDEV));
  assign fifo_full    = (cnt_q == CW'(DEPTH));
  assign fifo_empty   = (cnt_q == '0);
  assign pop          = ~fifo_empty & tty_ready;
  assign push_req     = data_wr & sel_zero;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push         = push_req & (~fifo_full | pop);
  assign drop         = push_req & fifo_full & ~pop;
  // Read side-effects use the qualifiers latched during the last io_e cycle.
  assign rd_data_end  = rd_end & ~rd_io_q & ~rd_da_q & rd_dev0_q;
  assign rd_stat_end  = rd_end & ~rd_io_q & rd_da_q;

  always_comb begin
    sel_d      = sel_q;
    dev_d      = dev_q;
    kbd_hold_d = kbd_hold_q;
    kbd_full_d = kbd_full_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (addr_wr) sel_d = bus_in;
    for (int k = 1; k < NDEV; k++)
      if (data_wr && sel_q == WIDTH'(k)) dev_d[k] = bus_in;
    dev_d[0] = '0;

    if (rd_data_end) kbd_full_d = 1'b0;
    else if (kbd_valid && !kbd_full_q) begin
      kbd_hold_d = kbd_data;
      kbd_full_d = 1'b1;
    end

    if (drop)             ovf_d = 1'b1;
    else if (rd_stat_end) ovf_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      io_s_q     <= 1'b0;
      io_e_q     <= 1'b0;
      rd_da_q    <= 1'b0;
      rd_io_q    <= 1'b0;
      rd_dev0_q  <= 1'b0;
      sel_q      <= '0;
      dev_q      <= '0;
      kbd_hold_q <= '0;
      kbd_full_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      io_s_q     <= io_s;
      io_e_q     <= io_e;
      if (io_e) begin
        rd_da_q   <= io_da;
        rd_io_q   <= io_io;
        rd_dev0_q <= sel_zero;
      end
      sel_q      <= sel_d;
      dev_q      <= dev_d;
      kbd_hold_q <= kbd_hold_d;
      kbd_full_q <= kbd_full_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && push) mem[wr_ptr_q] <= bus_in;
  end

  always_comb begin
    bus_out = '0;
    if (io_e && !io_io) begin
      if (io_da) begin
        bus_out[7] = kbd_full_q;
        bus_out[6] = fifo_full;
        bus_out[5] = fifo_empty;
        bus_out[4] = ovf_q;
      end else if (sel_zero) begin
        bus_out = kbd_full_q ? kbd_hold_q : '0;
      end else if (sel_in_range) begin
        bus_out = sw_in;
      end
    end
  end

  assign dev_sel   = sel_q;
  assign dev_out   = dev_q;
  assign tty_data  = mem[rd_ptr_q];
  assign tty_valid = ~fifo_empty;
  assign kbd_ready = ~kbd_full_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_jio_ctrl.sv
// Directed bench for jio_ctrl: queue-based device model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_jio_ctrl;
  localparam int W = 8, ND = 4, DP = 8;

  logic            CLK = 0, reset = 1;
  logic            io_s = 0, io_e = 0, io_da = 0, io_io = 0;
  logic [W-1:0]    bus_in = 0, sw_in = 0, kbd_data = 0;
  logic            tty_ready = 0, kbd_valid = 0;
  logic [W-1:0]    bus_out, dev_sel, tty_data;
  logic [ND*W-1:0] dev_out;
  logic            tty_valid, kbd_ready, ovf;

  int checks = 0, errors = 0;

  jio_ctrl #(.WIDTH(W), .NDEV(ND), .DEPTH(DP)) dut (
    .CLK(CLK), .reset(reset), .io_s(io_s), .io_e(io_e), .io_da(io_da), .io_io(io_io),
    .bus_in(bus_in), .bus_out(bus_out), .dev_sel(dev_sel), .dev_out(dev_out),
    .sw_in(sw_in), .tty_data(tty_data), .tty_valid(tty_valid), .tty_ready(tty_ready),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [W-1:0] q[$];
  logic [ND-1:0][W-1:0] m_dev;
  logic [W-1:0] m_sel, m_kbd;
  logic m_kfull, m_ovf, prev_s, prev_e, last_da, last_io;
  logic [W-1:0] last_sel;

  always @(posedge CLK) begin
    if (reset) begin
      q.delete(); m_dev = '0; m_sel = 0; m_kbd = 0; m_kfull = 0; m_ovf = 0;
      prev_s = 0; prev_e = 0; last_da = 0; last_io = 0; last_sel = 0;
    end else begin
      automatic logic set  = io_s && !prev_s;
      automatic logic rend = !io_e && prev_e;
      automatic logic popn = (q.size() > 0) && tty_ready;
      automatic logic kclr = rend && !last_io && !last_da && last_sel == 0;
      automatic logic [W-1:0] old_sel = m_sel;
      if (popn) void'(q.pop_front());
      if (set && io_io && io_da) m_sel = bus_in;
      if (set && io_io && !io_da) begin
        if (old_sel == 0) begin
          if (q.size() < DP) q.push_back(bus_in);
          else m_ovf = 1;
        end else if (old_sel < ND) m_dev[old_sel] = bus_in;
      end
      if (rend && !last_io && last_da && !(set && io_io && !io_da && old_sel == 0 && q.size() >= DP && !popn))
        m_ovf = 0;
      if (kclr) m_kfull = 0;
      else if (kbd_valid && !m_kfull) begin m_kbd = kbd_data; m_kfull = 1; end
      if (io_e) begin last_da = io_da; last_io = io_io; last_sel = old_sel; end
      prev_s = io_s; prev_e = io_e;
    end
  end

  function automatic logic [W-1:0] exp_bus();
    logic [W-1:0] r = 0;
    if (io_e && !io_io) begin
      if (io_da) r = {m_kfull, q.size() == DP, q.size() == 0, m_ovf, 4'h0};
      else if (m_sel == 0) r = m_kfull ? m_kbd : 0;
      else if (m_sel < ND) r = sw_in;
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (!reset) begin
      chk("bus_out", bus_out, exp_bus());
      chk("dev_sel", dev_sel, m_sel);
      chk("dev_out", dev_out, m_dev);
      chk("tty_valid", tty_valid, q.size() != 0);
      if (q.size() != 0) chk("tty_data", tty_data, q[0]);
      chk("kbd_ready", kbd_ready, !m_kfull);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic tick(); @(posedge CLK); #1; endtask

  task automatic io_wr(input logic da, input logic [W-1:0] v, input int hold);
    io_io = 1; io_da = da; bus_in = v; io_s = 1;
    repeat (hold) tick();
    io_s = 0; tick();
  endtask

  // Asserts io_e for one cycle, checks the bus value, then drops io_e.
  task automatic io_rd(input logic da, input logic [W-1:0] exp, input string name);
    io_io = 0; io_da = da; io_e = 1; tick();
    chk(name, bus_out, exp);
    io_e = 0; tick();
  endtask

  initial begin
    repeat (2) tick();
    reset = 0; tick();
    chk("rst_bus", bus_out, 0);
    chk("rst_valid", tty_valid, 0);
    chk("rst_kready", kbd_ready, 1);
    chk("rst_sel", dev_sel, 0);
    io_rd(1, 8'h20, "rst_status");

    // TTY write and drain
    io_wr(1, 0, 2);
    io_wr(0, 8'h41, 2);
    io_wr(0, 8'h42, 2);
    chk("tty_v1", tty_valid, 1);
    chk("tty_d41", tty_data, 8'h41);
    tty_ready = 1;
    tick(); chk("tty_d42", tty_data, 8'h42);
    tick(); tty_ready = 0;
    chk("tty_empty", tty_valid, 0);

    // long strobe, single latch write
    io_wr(1, 2, 2);
    io_wr(0, 8'h5A, 5);
    chk("dev2", dev_out[23:16], 8'h5A);
    chk("dev2_fifo", tty_valid, 0);

    // overflow and status clear
    io_wr(1, 0, 2);
    for (int i = 0; i < DP; i++) io_wr(0, W'(8'h10 + i), 2);
    chk("full_noovf", ovf, 0);
    io_wr(0, 8'hFF, 2);
    chk("ovf_set", ovf, 1);
    io_rd(1, 8'h50, "status_ovf");
    chk("ovf_clr", ovf, 0);
    io_rd(1, 8'h40, "status_full");

    // full FIFO, push and pop in one cycle
    tty_ready = 1; io_io = 1; io_da = 0; bus_in = 8'h77; io_s = 1; tick();
    tty_ready = 0; tick(); io_s = 0; tick();
    chk("pp_ovf", ovf, 0);
    chk("pp_head", tty_data, 8'h11);
    io_rd(1, 8'h40, "pp_status");
    tty_ready = 1;
    repeat (7) tick();
    chk("pp_tail", tty_data, 8'h77);
    tick(); tty_ready = 0;
    chk("pp_drained", tty_valid, 0);

    // keyboard
    kbd_data = 8'h33; kbd_valid = 1; tick(); kbd_valid = 0;
    chk("kbd_busy", kbd_ready, 0);
    io_rd(1, 8'hA0, "kbd_status");
    io_rd(0, 8'h33, "kbd_read");
    chk("kbd_freed", kbd_ready, 1);
    io_rd(0, 8'h00, "kbd_reread");

    // switches and out-of-range device
    sw_in = 8'hA5;
    io_wr(1, 1, 2);
    io_rd(0, 8'hA5, "sw_read");
    io_wr(1, 7, 2);
    io_wr(0, 8'h11, 3);
    chk("dev7_nolatch", dev_out, {8'h00, 8'h5A, 8'h00, 8'h00});
    io_rd(0, 8'h00, "dev7_read");

    // reset mid-fill
    io_wr(1, 0, 2);
    io_wr(0, 8'h01, 2);
    io_wr(0, 8'h02, 2);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_valid", tty_valid, 0);
    chk("mid_rst_sel", dev_sel, 0);
    tick();

    // io_s still high at reset release fires once
    io_io = 1; io_da = 0; bus_in = 8'h99; io_s = 1;
    reset = 1; tick(); reset = 0; tick();
    chk("rel_valid", tty_valid, 1);
    chk("rel_data", tty_data, 8'h99);
    tick(); io_s = 0; tick();
    tty_ready = 1; tick(); tty_ready = 0;
    chk("rel_single", tty_valid, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
